// File: rtl/reloj_controlador.sv
// Timing and mode controller for the digital clock: 1 Hz prescaler, carry chaining,
// RUN/SET_HOR/SET_MIN FSM and button debouncing. Optional auto-repeat: RELOJ_AUTO_REPEAT_EN.
module reloj_controlador #(
  parameter int CLK_HZ       = 50000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_CYC   = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_inc,
  input  logic       carry_seg,
  input  logic       carry_min,
  output logic       tick_1hz,
  output logic       inc_seg,
  output logic       inc_min,
  output logic       inc_hor,
  output logic       clr_seg,
  output logic [1:0] modo,
  output logic       parpadeo
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYC - 1);

  if (CLK_HZ < 4 || DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("reloj_controlador: invalid parameter setting");
  end

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HOR = 2'b01,
    SET_MIN = 2'b10
  } modo_t;

  modo_t         state, state_next;
  logic [1:0]    sync1, sync2, deb, deb_d;
  logic [DW-1:0] db_cnt [2];
  logic [PW-1:0] pre, pre_next;
  logic          edge_modo, edge_inc, inc_evt, in_run;
  logic          leave_min, hor_req, min_req, pre_wrap;
  logic          tick_d, inc_seg_d, inc_min_d, inc_hor_d, parp_d;

  // Index 0 is the mode button, index 1 the increment button.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_inc, btn_modo};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign edge_modo = deb[0] & ~deb_d[0];
  assign edge_inc  = deb[1] & ~deb_d[1];
  assign in_run    = (state != SET_HOR) && (state != SET_MIN);

`ifdef RELOJ_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  // Restarts at every fresh press so repeats are spaced from the initial edge.
  always_ff @(posedge clock) begin
    if (reset || !deb[1] || edge_inc || edge_modo || in_run) begin
      rep_cnt <= '0;
    end else if (rep_cnt == REP_MAX) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  assign rep_fire = deb[1] & ~edge_inc & ~in_run & (rep_cnt == REP_MAX);
  assign inc_evt  = edge_inc | rep_fire;
`else
  assign inc_evt = edge_inc;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A mode change always wins over a simultaneous increment request.
  always_comb begin
    state_next = state;
    leave_min  = 1'b0;
    hor_req    = 1'b0;
    min_req    = 1'b0;
    case (state)
      SET_HOR: begin
        hor_req = inc_evt & ~edge_modo;
        if (edge_modo) state_next = SET_MIN;
      end
      SET_MIN: begin
        min_req = inc_evt & ~edge_modo;
        if (edge_modo) begin
          state_next = RUN;
          leave_min  = 1'b1;
        end
      end
      default: begin
        if (edge_modo) state_next = SET_HOR;
      end
    endcase
    pre_wrap  = (pre == PRE_MAX);
    tick_d    = pre_wrap & ~leave_min;
    inc_seg_d = tick_d & in_run;
    inc_min_d = (tick_d & in_run & carry_seg) | min_req;
    inc_hor_d = (tick_d & in_run & carry_seg & carry_min) | hor_req;
    parp_d    = in_run | (pre < PRE_HALF);
    pre_next  = (pre_wrap || leave_min) ? '0 : pre + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre      <= '0;
      tick_1hz <= 1'b0;
      inc_seg  <= 1'b0;
      inc_min  <= 1'b0;
      inc_hor  <= 1'b0;
      clr_seg  <= 1'b0;
      parpadeo <= 1'b1;
    end else begin
      pre      <= pre_next;
      tick_1hz <= tick_d;
      inc_seg  <= inc_seg_d;
      inc_min  <= inc_min_d;
      inc_hor  <= inc_hor_d;
      clr_seg  <= leave_min;
      parpadeo <= parp_d;
    end
  end

  assign modo = state;

endmodule

// File: tb/tb_reloj_controlador.sv
// Scoreboard bench for reloj_controlador: expected pulse vectors are queued by cycle
// as stimulus is driven and compared when the DUT pulses or the cycle is reached.
module tb_reloj_controlador;

  localparam int TB_CLK_HZ = 10;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_modo, btn_inc, carry_seg, carry_min;
  logic       tick_1hz, inc_seg, inc_min, inc_hor, clr_seg, parpadeo;
  logic [1:0] modo;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       expq [$];
  logic [4:0] mon_vec;
  exp_t       mon_e;

  reloj_controlador #(
    .CLK_HZ      (TB_CLK_HZ),
    .DEBOUNCE_CYC(4),
    .REPEAT_CYC  (20)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_modo (btn_modo),
    .btn_inc  (btn_inc),
    .carry_seg(carry_seg),
    .carry_min(carry_min),
    .tick_1hz (tick_1hz),
    .inc_seg  (inc_seg),
    .inc_min  (inc_min),
    .inc_hor  (inc_hor),
    .clr_seg  (clr_seg),
    .modo     (modo),
    .parpadeo (parpadeo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic i, input int n);
    btn_modo = m;
    btn_inc  = i;
    repeat (n) @(negedge clock);
  endtask

  task automatic waitUntil(input int target);
    if (cyc > target) checkOutput("schedule", cyc, target);
    while (cyc < target) @(negedge clock);
  endtask

  // Keeps the queue sorted by cycle; events landing on the same cycle are merged.
  task automatic pushExp(input int at, input logic [4:0] v);
    exp_t e;
    int   idx;
    bit   merged;
    idx    = expq.size();
    merged = 1'b0;
    for (int i = expq.size() - 1; i >= 0; i--) begin
      if (!merged && expq[i].cyc == at) begin
        e       = expq[i];
        e.vec   = e.vec | v;
        expq[i] = e;
        merged  = 1'b1;
      end else if (expq[i].cyc > at) begin
        idx = i;
      end
    end
    if (!merged) begin
      e.cyc = at;
      e.vec = v;
      expq.insert(idx, e);
    end
  endtask

  task automatic pushTicks(input int o, input int lo, input int hi, input logic [4:0] v);
    for (int t = o + TB_CLK_HZ; t <= hi; t += TB_CLK_HZ) begin
      if (t >= lo) pushExp(t, v);
    end
  endtask

  // Vector order: {tick_1hz, inc_seg, inc_min, inc_hor, clr_seg}
  always @(negedge clock) begin
    mon_vec = {tick_1hz, inc_seg, inc_min, inc_hor, clr_seg};
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      mon_e = expq.pop_front();
      checkOutput($sformatf("pulses@%0d", cyc), 32'(mon_vec), 32'(mon_e.vec));
    end else if (mon_vec != 5'b0) begin
      checkOutput($sformatf("spurious@%0d", cyc), 32'(mon_vec), 32'(0));
    end
  end

  initial begin
    repeat (2000) @(posedge clock);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int org;
    int highs;
    reset     = 1'b1;
    btn_modo  = 1'b0;
    btn_inc   = 1'b0;
    carry_seg = 1'b0;
    carry_min = 1'b0;

    waitUntil(2);
    checkOutput("rst_modo", 32'(modo), 0);
    checkOutput("rst_parpadeo", 32'(parpadeo), 1);
    waitUntil(3);
    reset = 1'b0;
    org   = cyc;

    // RUN with no carries, then with seconds carry, then with both carries
    pushTicks(org, org + 1, org + 30, 5'b11000);
    waitUntil(org + 20);
    checkOutput("run_modo", 32'(modo), 0);
    checkOutput("run_parpadeo", 32'(parpadeo), 1);
    waitUntil(org + 35);
    carry_seg = 1'b1;
    pushTicks(org, org + 31, org + 50, 5'b11100);
    waitUntil(org + 55);
    carry_min = 1'b1;
    pushTicks(org, org + 51, org + 70, 5'b11110);
    waitUntil(org + 75);
    carry_seg = 1'b0;
    carry_min = 1'b0;
    pushTicks(org, org + 71, org + 85, 5'b11000);

    // RUN -> SET_HOR, then a bouncy increment press
    waitUntil(org + 78);
    pushTicks(org, org + 86, org + 130, 5'b10000);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1);
    waitUntil(org + 86);
    checkOutput("modo_set_hor", 32'(modo), 1);
    waitUntil(org + 87);
    pushExp(org + 98, 5'b00010);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b0, 1'b0, 1);

    waitUntil(org + 100);
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      if (parpadeo === 1'b1) highs++;
      @(negedge clock);
    end
    checkOutput("parpadeo_duty", 32'(highs), 10);

    // SET_HOR -> SET_MIN, then a long increment hold
    waitUntil(org + 128);
    pushTicks(org, org + 131, org + 200, 5'b10000);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1);
    waitUntil(org + 136);
    checkOutput("modo_set_min", 32'(modo), 2);
    waitUntil(org + 137);
    pushExp(org + 144, 5'b00100);
`ifdef RELOJ_AUTO_REPEAT_EN
    pushExp(org + 164, 5'b00100);
    pushExp(org + 184, 5'b00100);
`endif
    applyStimulus(1'b0, 1'b1, 50);
    applyStimulus(1'b0, 1'b0, 1);

    // SET_MIN -> RUN landing on a prescaler wrap: clr_seg only, tick suppressed
    waitUntil(org + 203);
    pushExp(org + 210, 5'b00001);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1);
    waitUntil(org + 211);
    checkOutput("modo_back_run", 32'(modo), 0);
    org = org + 210;
    pushTicks(org, org + 1, org + 20, 5'b11000);

    // Step to SET_MIN again, then both buttons together
    waitUntil(org + 18);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1);
    pushTicks(org, org + 21, org + 40, 5'b10000);
    waitUntil(org + 26);
    checkOutput("modo_set_hor2", 32'(modo), 1);
    waitUntil(org + 38);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1);
    pushTicks(org, org + 41, org + 60, 5'b10000);
    waitUntil(org + 46);
    checkOutput("modo_set_min2", 32'(modo), 2);
    waitUntil(org + 58);
    pushExp(org + 65, 5'b00001);
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 1);
    waitUntil(org + 66);
    checkOutput("modo_simultaneous", 32'(modo), 0);
    org = org + 65;
    pushTicks(org, org + 1, org + 10, 5'b11000);

    // Reset landing mid-debounce of a mode press
    waitUntil(org + 12);
    applyStimulus(1'b1, 1'b0, 3);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    btn_modo = 1'b0;
    org      = org + 17;
    pushTicks(org, org + 1, org + 20, 5'b11000);
    waitUntil(org + 12);
    checkOutput("modo_after_reset", 32'(modo), 0);
    waitUntil(org + 25);
    checkOutput("queue_drained", 32'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reloj_controlador.md
Name: reloj_controlador

Overview:
- Timing and mode controller for the digital clock.
- Generates the 1 Hz time base and one-cycle increment enables for the seconds, minutes and hours counters.
- Chains counter carries, runs a RUN / SET_HOR / SET_MIN setting FSM, and debounces the two front-panel buttons.
- Sits between the board buttons and the counter datapath; the counters keep their own values and wrap logic, and this block only sequences them.

Parameters:
- CLK_HZ, 50000000, clock cycles per 1 Hz tick; minimum 4.
- DEBOUNCE_CYC, 500000, consecutive stable cycles required before a debounced button level changes.
- REPEAT_CYC, 25000000, hold time between auto-repeat pulses; used only under the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_modo  in  1  raw mode button, asynchronous, active-high.
- btn_inc  in  1  raw increment button, asynchronous, active-high.
- carry_seg  in  1  seconds counter currently at 59.
- carry_min  in  1  minutes counter currently at 59.
- tick_1hz  out  1  one-cycle pulse, once per CLK_HZ cycles.
- inc_seg  out  1  seconds counter increment enable.
- inc_min  out  1  minutes counter increment enable.
- inc_hor  out  1  hours counter increment enable.
- clr_seg  out  1  one-cycle synchronous clear for the seconds counter.
- modo  out  2  current mode: 00 RUN, 01 SET_HOR, 10 SET_MIN.
- parpadeo  out  1  display blink gate; 1 means show digits.

Behaviour:
- Reset:
  - Sampled on the rising edge of clock, active-high.
  - Forces modo=00 and prescaler=0.
  - Clears synchronizers, debounced levels, edge registers and the repeat counter.
  - All pulse outputs are 0; parpadeo=1.
  - Reset mid-operation aborts any pending edge or debounce with no residual pulse.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer.
  - Debounce counter resets whenever the synchronized input equals the debounced level.
  - When the counter reaches DEBOUNCE_CYC-1 with the input still different, the debounced level updates.
  - A rising edge of a debounced level yields one-cycle edge_modo / edge_inc.
  - Latency from a clean button press to the edge: 2 + DEBOUNCE_CYC cycles.
- Prescaler:
  - Counts 0..CLK_HZ-1, wraps to 0, and runs in every mode.
  - tick_1hz is registered and asserted in the cycle after the prescaler equals CLK_HZ-1.
- RUN (00):
  - inc_seg = tick_1hz.
  - inc_min = tick_1hz & carry_seg.
  - inc_hor = tick_1hz & carry_seg & carry_min.
  - All three are registered in the same cycle as tick_1hz; carries are sampled at the compare cycle.
  - edge_inc is ignored.
- SET_HOR (01):
  - inc_seg=0 and inc_min=0; seconds are frozen.
  - edge_inc produces inc_hor=1 for exactly one cycle, registered one cycle after the edge.
- SET_MIN (10):
  - edge_inc produces inc_min=1 for exactly one cycle; no carry is propagated to hours.
  - inc_seg=0 and inc_hor=0.
- Mode FSM:
  - edge_modo steps RUN→SET_HOR→SET_MIN→RUN. Code 11 is unreachable and decodes as RUN.
  - On the SET_MIN→RUN transition, clr_seg pulses for one cycle and the prescaler reloads 0, so the first tick comes CLK_HZ cycles later.
- parpadeo:
  - 1 in RUN.
  - In set modes, 1 while prescaler < CLK_HZ/2, else 0 (registered).
- Simultaneous events:
  - edge_modo and edge_inc in the same cycle: the mode change wins and the increment is dropped.
  - A tick arriving in the same cycle as the SET_MIN→RUN transition is suppressed.
  - Pulses are never longer than one cycle.

Optional Feature:
- Macro: RELOJ_AUTO_REPEAT_EN.
- When defined:
  - In SET_HOR or SET_MIN, while the debounced btn_inc stays high, an additional increment pulse fires every REPEAT_CYC cycles after the initial edge.
  - The repeat counter clears on release, on a mode change and on reset.
- When undefined:
  - Exactly one increment per press.
  - No repeat counter is synthesized.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=10, DEBOUNCE_CYC=4, REPEAT_CYC=20.
- Reset held for 3 cycles, then released with no buttons → tick_1hz/inc_seg pulse every 10 cycles, first at cycle 10 after release; modo=00, parpadeo=1, inc_min=inc_hor=0.
- carry_seg=1, carry_min=0 in RUN → inc_min coincides with each tick, inc_hor=0. With carry_seg=1 and carry_min=1 → inc_seg, inc_min and inc_hor all high in the same cycle.
- btn_modo pulsed 6 cycles, three times → modo sequence 01, 10, 00. clr_seg is a single pulse at the 10→00 transition. The next tick occurs exactly 10 cycles after clr_seg.
- In SET_HOR, btn_inc bounce (1,0,1,0, then 1 held 8 cycles) → exactly one inc_hor, 2+4+1 cycles after the stable rise. No inc_seg while in set mode. parpadeo runs 5 cycles high / 5 cycles low.
- btn_modo and btn_inc rising together in SET_MIN → modo goes to 00, no inc_min. Reset asserted 2 cycles into a debounce → no pulse emitted afterwards.
- With RELOJ_AUTO_REPEAT_EN and btn_inc held 50 cycles in SET_MIN → inc_min at the edge, then at +20 and +40 (3 pulses total). Without the macro → 1 pulse.
